// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: start/WIDTH data/stop frames sampled on
// ser_en strobes, presented as WIDTH-bit words on a one-deep valid/ready port.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   ser_in         serial line (idles high)
//   ser_en         bit strobe; ser_in is sampled only when high
//   dout           received word, held while dout_valid && !dout_ready
//   dout_valid     dout holds an unconsumed word
//   dout_ready     consumer accepts dout when dout_valid is high
//   busy           receiver is not idle
//   frame_err      one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: good word dropped, output buffer full
module serial_word_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n, sr_shift;
    logic [WIDTH-1:0] dout_n;
    logic             valid_n;
    logic             ferr_n;
    logic             ovr_n;

    if (MSB_FIRST) begin : g_msb
        assign sr_shift = {sr[WIDTH-2:0], ser_in};
    end else begin : g_lsb
        assign sr_shift = {ser_in, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sr         <= sr_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            frame_err  <= ferr_n;
            overrun    <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        dout_n  = dout;
        valid_n = dout_valid;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;

        // A transfer empties the buffer unless a new word loads below.
        if (dout_valid && dout_ready) begin
            valid_n = 1'b0;
        end

        if (ser_en) begin
            unique case (state)
                IDLE: begin
                    if (!ser_in) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    sr_n  = sr_shift;
                    cnt_n = cnt + CW'(1);
                    if (cnt == LAST) begin
                        state_n = STOP;
                    end
                end
                STOP: begin
                    if (ser_in) begin
                        state_n = IDLE;
                        // Buffer counts as free if it drains this same edge.
                        if (!dout_valid || dout_ready) begin
                            dout_n  = sr;
                            valid_n = 1'b1;
                        end else begin
                            ovr_n = 1'b1;
                        end
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (ser_in) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Testbench for serial_word_receiver: LSB-first and MSB-first instances share
// one serial stream and are compared against a queue-based frame model.
module tb_serial_word_receiver;

    logic       clk;
    logic       reset;
    logic       ser_in;
    logic       ser_en;
    logic       dout_ready;
    logic [7:0] dout_l, dout_m;
    logic       valid_l, valid_m;
    logic       busy_l, busy_m;
    logic       ferr_l, ferr_m;
    logic       ovr_l, ovr_m;

    int n_checks = 0;
    int n_pass   = 0;

    serial_word_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .ser_in     (ser_in),
        .ser_en     (ser_en),
        .dout       (dout_l),
        .dout_valid (valid_l),
        .dout_ready (dout_ready),
        .busy       (busy_l),
        .frame_err  (ferr_l),
        .overrun    (ovr_l)
    );

    serial_word_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .ser_in     (ser_in),
        .ser_en     (ser_en),
        .dout       (dout_m),
        .dout_valid (valid_m),
        .dout_ready (dout_ready),
        .busy       (busy_m),
        .frame_err  (ferr_m),
        .overrun    (ovr_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: collects the bits of a frame in a queue and judges
    // the frame once data plus stop bit have arrived.
    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_WAIT  = 2;

    int         mode;
    bit         q[$];
    logic [7:0] e_dl, e_dm;
    bit         e_v, e_b, e_fe, e_ov;

    task automatic model_reset();
        mode = M_IDLE;
        q.delete();
        e_dl = 8'h00;
        e_dm = 8'h00;
        e_v  = 1'b0;
        e_b  = 1'b0;
        e_fe = 1'b0;
        e_ov = 1'b0;
    endtask

    task automatic model_update(input bit in, input bit en, input bit rdy);
        bit free;
        free = !e_v || rdy;
        e_fe = 1'b0;
        e_ov = 1'b0;
        if (e_v && rdy) e_v = 1'b0;
        if (en) begin
            if (mode == M_IDLE) begin
                if (!in) begin
                    mode = M_FRAME;
                    q.delete();
                end
            end else if (mode == M_FRAME) begin
                if (q.size() < 8) begin
                    q.push_back(in);
                end else if (in) begin
                    mode = M_IDLE;
                    if (free) begin
                        for (int i = 0; i < 8; i++) begin
                            e_dl[i]     = q[i];
                            e_dm[7 - i] = q[i];
                        end
                        e_v = 1'b1;
                    end else begin
                        e_ov = 1'b1;
                    end
                end else begin
                    e_fe = 1'b1;
                    mode = M_WAIT;
                end
            end else begin
                if (in) mode = M_IDLE;
            end
        end
        e_b = (mode != M_IDLE);
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        else
            n_pass++;
    endtask

    task automatic check_all();
        chk("lsb_dout", dout_l, e_dl);
        chk("lsb_valid", {7'b0, valid_l}, {7'b0, e_v});
        chk("lsb_busy", {7'b0, busy_l}, {7'b0, e_b});
        chk("lsb_ferr", {7'b0, ferr_l}, {7'b0, e_fe});
        chk("lsb_ovr", {7'b0, ovr_l}, {7'b0, e_ov});
        chk("msb_dout", dout_m, e_dm);
        chk("msb_valid", {7'b0, valid_m}, {7'b0, e_v});
        chk("msb_busy", {7'b0, busy_m}, {7'b0, e_b});
        chk("msb_ferr", {7'b0, ferr_m}, {7'b0, e_fe});
        chk("msb_ovr", {7'b0, ovr_m}, {7'b0, e_ov});
    endtask

    task automatic step();
        @(posedge clk);
        model_update(ser_in, ser_en, dout_ready);
        #1;
        check_all();
    endtask

    task automatic send_bit(input bit b, input int gap);
        repeat (gap) begin
            ser_en = 1'b0;
            ser_in = 1'($urandom);
            step();
        end
        ser_en = 1'b1;
        ser_in = b;
        step();
    endtask

    // Bits go out in word order w[0] first; rdy_stop forces dout_ready
    // high only on the stop-bit cycle.
    task automatic send_frame(input logic [7:0] w, input int gap,
                              input bit stop, input bit rdy_stop);
        bit keep;
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(w[i], gap);
        keep = dout_ready;
        if (rdy_stop) dout_ready = 1'b1;
        send_bit(stop, gap);
        dout_ready = keep;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ser_en = 1'b1;
            ser_in = 1'b1;
            step();
        end
    endtask

    typedef struct {
        bit         in;
        bit         en;
        bit         rdy;
        logic [7:0] dl;
        logic [7:0] dm;
        bit         v;
        bit         b;
        bit         fe;
        bit         ov;
    } vec_t;

    vec_t tbl[11];
    bit   seq[11];

    initial begin
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            tbl[i].in  = seq[i];
            tbl[i].en  = 1'b1;
            tbl[i].rdy = 1'b1;
            tbl[i].dl  = (i >= 9) ? 8'h4D : 8'h00;
            tbl[i].dm  = (i >= 9) ? 8'hB2 : 8'h00;
            tbl[i].v   = (i == 9);
            tbl[i].b   = (i <= 8);
            tbl[i].fe  = 1'b0;
            tbl[i].ov  = 1'b0;
        end

        reset      = 1'b1;
        ser_in     = 1'b1;
        ser_en     = 1'b0;
        dout_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Basic frame, continuous strobe.
        for (int i = 0; i < 11; i++) begin
            ser_in     = tbl[i].in;
            ser_en     = tbl[i].en;
            dout_ready = tbl[i].rdy;
            step();
            chk("tbl_dout_l", dout_l, tbl[i].dl);
            chk("tbl_dout_m", dout_m, tbl[i].dm);
            chk("tbl_valid", {7'b0, valid_l}, {7'b0, tbl[i].v});
            chk("tbl_busy", {7'b0, busy_l}, {7'b0, tbl[i].b});
            chk("tbl_ferr", {7'b0, ferr_l}, {7'b0, tbl[i].fe});
            chk("tbl_ovr", {7'b0, ovr_l}, {7'b0, tbl[i].ov});
        end

        // Sparse strobe, noise on non-strobe cycles.
        send_frame(8'hA5, 3, 1'b1, 1'b0);
        chk("sparse_dout", dout_l, 8'hA5);
        chk("sparse_valid", {7'b0, valid_l}, 8'h01);
        idle(1);

        // Backpressure: second word dropped.
        dout_ready = 1'b0;
        send_frame(8'h11, 0, 1'b1, 1'b0);
        send_frame(8'h22, 0, 1'b1, 1'b0);
        chk("bp_ovr", {7'b0, ovr_l}, 8'h01);
        chk("bp_dout", dout_l, 8'h11);
        chk("bp_valid", {7'b0, valid_l}, 8'h01);
        idle(1);
        chk("bp_ovr_gone", {7'b0, ovr_l}, 8'h00);
        chk("bp_hold", dout_l, 8'h11);
        dout_ready = 1'b1;
        idle(1);
        chk("bp_drain", {7'b0, valid_l}, 8'h00);

        // Ready on the exact second-stop edge.
        dout_ready = 1'b0;
        send_frame(8'h11, 0, 1'b1, 1'b0);
        send_frame(8'h22, 0, 1'b1, 1'b1);
        chk("rs_dout", dout_l, 8'h22);
        chk("rs_valid", {7'b0, valid_l}, 8'h01);
        chk("rs_ovr", {7'b0, ovr_l}, 8'h00);
        dout_ready = 1'b1;
        idle(1);

        // Frame error, held-low line, recovery.
        send_frame(8'h5A, 0, 1'b0, 1'b0);
        chk("fe_pulse", {7'b0, ferr_l}, 8'h01);
        chk("fe_novalid", {7'b0, valid_l}, 8'h00);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
        chk("fe_busy", {7'b0, busy_l}, 8'h01);
        chk("fe_ferr_once", {7'b0, ferr_l}, 8'h00);
        send_bit(1'b1, 0);
        chk("fe_idle", {7'b0, busy_l}, 8'h00);
        send_frame(8'h3C, 0, 1'b1, 1'b0);
        chk("fe_dout", dout_l, 8'h3C);
        idle(1);

        // Reset after 4 data bits.
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send_frame(8'hFF, 0, 1'b1, 1'b0);
        chk("rst_dout", dout_l, 8'hFF);
        chk("rst_valid", {7'b0, valid_l}, 8'h01);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ser_en     = ($urandom_range(0, 3) != 0);
            ser_in     = ($urandom_range(0, 2) != 0);
            dout_ready = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
